d_flip_flop: RTL and testbench

Edge-triggered D-type register: samples `data_in` on every rising edge of `clock` and presents it on `data_out` after a configurable number of stages. It is the basic storage/retiming primitive used wherever a signal must be registered or delayed by whole clock cycles. It has a synchronous, active-high reset to a programmable value and no other control inputs.

---
 rtl/d_flip_flop.sv | 50 +++++
 tb/tb_d_flip_flop.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/d_flip_flop.sv
// d_flip_flop: cascaded D-type register chain.
// data_in is sampled on every rising clock edge and reaches data_out after
// STAGES edges. A synchronous, active-high reset loads RESET_VALUE into every
// stage, which discards any samples still in flight. data_out is taken
// straight from the last flop, so there is no combinational input-to-output
// path.
module d_flip_flop #(
   parameter int              WIDTH       = 1,
   parameter int              STAGES      = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out
);

   // Reject degenerate configurations at elaboration time
   if (WIDTH < 1) begin : g_bad_width
      $fatal(1, "d_flip_flop: WIDTH must be at least 1");
   end
   if (STAGES < 1) begin : g_bad_stages
      $fatal(1, "d_flip_flop: STAGES must be at least 1");
   end

   // One flop per stage; each stage gets its own generate scope so that
   // exactly one always_ff drives each register.
   for (genvar g = 0; g < STAGES; g++) begin : g_stage
      logic [WIDTH-1:0] r_q;
      logic [WIDTH-1:0] w_d;

      if (g == 0) begin : g_head
         assign w_d = data_in;
      end else begin : g_link
         assign w_d = g_stage[g-1].r_q;
      end

      // Reset has priority over the shift; otherwise take the upstream value
      always_ff @(posedge clock) begin
         if (reset) begin
            r_q <= RESET_VALUE;
         end else begin
            r_q <= w_d;
         end
      end
   end

   assign data_out = g_stage[STAGES-1].r_q;

endmodule

// File: tb/tb_d_flip_flop.sv
// tb_d_flip_flop: directed checks of d_flip_flop in two configurations.
//   u_dff1 : defaults (WIDTH=1, STAGES=1, RESET_VALUE=0)
//   u_dff8 : WIDTH=8, STAGES=3, RESET_VALUE=8'hA5
// Rising edges fall at 100, 300, 500, ... (period 200). A model records the
// pre-edge (reset, data) pair for every edge and derives the expected output
// from the rule "output after edge k is the sample from edge k-STAGES+1,
// unless a reset edge lies inside that window, in which case RESET_VALUE".
module tb_d_flip_flop;

   logic       clk;
   logic       rst1;
   logic       d1;
   logic       q1;
   logic       rst8;
   logic [7:0] d8;
   logic [7:0] q8;

   int n_checks = 0;
   int n_errors = 0;

   // Per-edge history: index 0 = default DUT, index 1 = 8-bit/3-stage DUT
   bit         h_rst [2][64];
   logic [7:0] h_dat [2][64];

   d_flip_flop u_dff1 (
      .clock    (clk),
      .reset    (rst1),
      .data_in  (d1),
      .data_out (q1)
   );

   d_flip_flop #(
      .WIDTH       (8),
      .STAGES      (3),
      .RESET_VALUE (8'hA5)
   ) u_dff8 (
      .clock    (clk),
      .reset    (rst8),
      .data_in  (d8),
      .data_out (q8)
   );

   initial begin
      clk = 1'b0;
      forever #100 clk = ~clk;
   end

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
      end
   endtask

   // Expected output after edge k for history slot u; def=0 while the
   // chain still holds pre-reset unknowns.
   function automatic void model(input int u, input int s, input logic [7:0] rv,
                                 input int k, output logic [7:0] e, output bit def);
      bit hit;
      hit = 1'b0;
      for (int j = k - s + 1; j <= k; j++) begin
         if (j >= 0 && h_rst[u][j]) hit = 1'b1;
      end
      if (hit) begin
         def = 1'b1;
         e   = rv;
      end else if (k - s + 1 >= 0) begin
         def = 1'b1;
         e   = h_dat[u][k-s+1];
      end else begin
         def = 1'b0;
         e   = 8'hxx;
      end
   endfunction

   // Snapshot inputs 1 time unit before each edge, compare 50 after it
   initial begin : model_check
      logic [7:0] e;
      bit         def;
      int         k;
      k = 0;
      #99;
      forever begin
         if (k < 64) begin
            h_rst[0][k] = rst1;
            h_dat[0][k] = {7'b0, d1};
            h_rst[1][k] = rst8;
            h_dat[1][k] = d8;
         end
         #51;
         if (k < 64) begin
            model(0, 1, 8'h00, k, e, def);
            if (def) check("model_q1", {7'b0, q1}, e);
            model(1, 3, 8'hA5, k, e, def);
            if (def) check("model_q8", q8, e);
         end
         k++;
         #149;
      end
   end

   task automatic goto(input longint t);
      #(t - $time);
   endtask

   // Directed stimulus plus literal expectations that pin the model
   initial begin : stimulus
      rst1 = 1'b1;
      d1   = 1'b0;
      rst8 = 1'b1;
      d8   = 8'h00;

      goto(120);  check("basic_reset_q1", {7'b0, q1}, 8'h00);
      goto(200);  rst1 = 1'b0; d1 = 1'b1;
      goto(320);  check("basic_capture_q1", {7'b0, q1}, 8'h01);
      goto(350);  rst1 = 1'b1;
      goto(400);  rst8 = 1'b0; d8 = 8'h01;
      goto(450);  rst1 = 1'b0;
      goto(520);  check("reset_between_edges_q1", {7'b0, q1}, 8'h01);
                  check("ms_fill0_q8", q8, 8'hA5);
      goto(600);  d8 = 8'h02;
      goto(720);  check("basic_hold_q1", {7'b0, q1}, 8'h01);
                  check("ms_fill1_q8", q8, 8'hA5);
      goto(800);  d1 = 1'b0; d8 = 8'h03;
      goto(920);  check("fall_q1", {7'b0, q1}, 8'h00);
                  check("ms_first_q8", q8, 8'h01);
      goto(1000); d8 = 8'h04;
      goto(1120); check("ms_second_q8", q8, 8'h02);
      goto(1200); d8 = 8'h05;
      goto(1300);
      // Edge-aligned change: scheduled after the flops read their inputs,
      // so the edge at 1300 must still capture the old value 0.
      d1 <= 1'b1;
      goto(1320); check("same_step_old_q1", {7'b0, q1}, 8'h00);
                  check("ms_third_q8", q8, 8'h03);
      goto(1400); rst8 = 1'b1;
      goto(1520); check("same_step_new_q1", {7'b0, q1}, 8'h01);
                  check("ms_reset_q8", q8, 8'hA5);
      goto(1600); rst8 = 1'b0; d8 = 8'h01;
      goto(1720); check("pre_reset_q1", {7'b0, q1}, 8'h01);
      goto(1800); rst1 = 1'b1; d8 = 8'h02;
      goto(1920); check("sync_reset_q1", {7'b0, q1}, 8'h00);
                  check("mid_fill_q8", q8, 8'hA5);
      goto(2000); rst1 = 1'b0; rst8 = 1'b1;
      goto(2120); check("post_reset_q1", {7'b0, q1}, 8'h01);
                  check("midstream_reset_q8", q8, 8'hA5);
      goto(2200); rst8 = 1'b0; d8 = 8'h10;
      goto(2400); d8 = 8'h11;
      goto(2520); check("mid_refill_q8", q8, 8'hA5);
      goto(2720); check("mid_first_q8", q8, 8'h10);
      goto(2900);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
